// File: rtl/isa_pkg.sv
// isa_pkg
//   Shared ISA encodings used by the decoder and the execution resources.
//   Only the SPECIAL-class func codes consumed by the HI/LO mul/div unit
//   live here.
//   No ports (package).
package isa_pkg;

    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Types and helpers shared by the mul/div sequencer, its step unit and
//   its bus interface: state encoding, default operand width, counter
//   width derivation and func-code decode helpers.
//   No ports (package).
package muldiv_pkg;

    import isa_pkg::*;

    localparam int MULDIV_XLEN = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Counter must hold XLEN-1 down to 0.
    function automatic int cnt_width(input int xlen);
        return (xlen > 2) ? $clog2(xlen) : 1;
    endfunction

    function automatic logic is_muldiv_op(input logic [5:0] func);
        return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
               (func == FUNC_DIV)  || (func == FUNC_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [5:0] func);
        return (func == FUNC_DIV) || (func == FUNC_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] func);
        return (func == FUNC_MULT) || (func == FUNC_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if
//   Decode <-> mul/div sequencer bundle.
//   master (decode):    drives w_start, w_op_type_6, w_rs_data_32,
//                       w_rt_data_32, w_mf_req; observes w_busy, w_stall,
//                       w_done, w_hi_32, w_lo_32.
//   slave (sequencer):  the mirror image.
interface muldiv_if import muldiv_pkg::*; #(
    parameter int XLEN = MULDIV_XLEN
) ();

    logic            w_start;
    logic [5:0]      w_op_type_6;
    logic [XLEN-1:0] w_rs_data_32;
    logic [XLEN-1:0] w_rt_data_32;
    logic            w_mf_req;
    logic            w_busy;
    logic            w_stall;
    logic            w_done;
    logic [XLEN-1:0] w_hi_32;
    logic [XLEN-1:0] w_lo_32;

    modport master (
        output w_start, w_op_type_6, w_rs_data_32, w_rt_data_32, w_mf_req,
        input  w_busy, w_stall, w_done, w_hi_32, w_lo_32
    );

    modport slave (
        input  w_start, w_op_type_6, w_rs_data_32, w_rt_data_32, w_mf_req,
        output w_busy, w_stall, w_done, w_hi_32, w_lo_32
    );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step
//   Combinational single iteration of the unsigned mul/div datapath.
//   Ports:
//     is_div   in   1       select restoring-divide step (else add-shift)
//     acc_in   in   2*XLEN  multiply: {partial product, remaining multiplier}
//                           divide:   {partial remainder, dividend/quotient}
//     operand  in   XLEN    multiplicand or divisor (magnitude)
//     acc_out  out  2*XLEN  accumulator after this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_wide;
    logic [XLEN-1:0] rem_sub;
    logic            fits;

    // The multiply sum keeps its carry so the right shift brings it into the
    // top bit. The divide trial uses XLEN+1 bits for the shifted remainder;
    // when the divisor fits the difference is below the divisor, so the low
    // XLEN bits of a modular subtract are exact.
    always_comb begin
        mul_sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        rem_wide = acc_in[2*XLEN-1:XLEN-1];
        fits     = rem_wide >= {1'b0, operand};
        rem_sub  = rem_wide[XLEN-1:0] - operand;
        acc_out  = {mul_sum, acc_in[XLEN-1:1]};
        if (is_div) begin
            acc_out = fits ? {rem_sub, acc_in[XLEN-2:0], 1'b1}
                           : {rem_wide[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
//   One bit per cycle: 1 PREP + XLEN ITER + 1 FIX cycles busy, then DONE.
//   Ports:
//     clock  in  system clock, rising edge
//     reset  in  synchronous, active-low
//     bus    muldiv_if.slave: issue/operands/MF request in,
//            busy/stall/done/HI/LO out
module muldiv_sequencer import muldiv_pkg::*; #(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int CW = cnt_width(XLEN);

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_step;
    logic [XLEN-1:0]   operand_b, rs_q, rt_q, hi_q, lo_q;
    logic              op_div, op_signed, neg_main, neg_rem, div_zero;
    logic              busy, done, issue_ok;
    logic              rs_neg, rt_neg;
    logic [XLEN-1:0]   rs_abs, rt_abs;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed, rem_fixed;

    // Issues are only taken while no operation is in flight; an unknown
    // func code is simply dropped.
    assign issue_ok = ((state == IDLE) || (state == DONE)) && bus.w_start &&
                      is_muldiv_op(bus.w_op_type_6);

    assign rs_neg = op_signed & rs_q[XLEN-1];
    assign rt_neg = op_signed & rt_q[XLEN-1];
    assign rs_abs = rs_neg ? -rs_q : rs_q;
    assign rt_abs = rt_neg ? -rt_q : rt_q;

    assign prod_fixed = neg_main ? -acc : acc;
    assign quo_fixed  = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fixed  = neg_rem  ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_div),
        .acc_in  (acc),
        .operand (operand_b),
        .acc_out (acc_step)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue_ok) state_next = PREP;
            PREP:    state_next = ITER;
            ITER:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = issue_ok ? PREP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs.
    always_comb begin
        busy = (state == PREP) || (state == ITER) || (state == FIX);
        done = (state == DONE);
    end

    // Datapath. Signed ops run on magnitudes; signs are reapplied in FIX,
    // the only state that touches HI/LO. Divide by zero bypasses the
    // sign fix-up and commits the all-ones quotient and raw dividend.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt       <= '0;
            acc       <= '0;
            operand_b <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (issue_ok) begin
                        rs_q      <= bus.w_rs_data_32;
                        rt_q      <= bus.w_rt_data_32;
                        op_div    <= is_div_op(bus.w_op_type_6);
                        op_signed <= is_signed_op(bus.w_op_type_6);
                    end
                end
                PREP: begin
                    neg_main <= rs_neg ^ rt_neg;
                    neg_rem  <= rs_neg;
                    div_zero <= (rt_q == '0);
                    cnt      <= CW'(XLEN - 1);
                    if (op_div) begin
                        acc       <= {{XLEN{1'b0}}, rs_abs};
                        operand_b <= rt_abs;
                    end else begin
                        acc       <= {{XLEN{1'b0}}, rt_abs};
                        operand_b <= rs_abs;
                    end
                end
                ITER: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    if (!op_div) begin
                        {hi_q, lo_q} <= prod_fixed;
                    end else if (div_zero) begin
                        lo_q <= '1;
                        hi_q <= rs_q;
                    end else begin
                        lo_q <= quo_fixed;
                        hi_q <= rem_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.w_busy  = busy;
    assign bus.w_stall = busy & (bus.w_start | bus.w_mf_req);
    assign bus.w_done  = done;
    assign bus.w_hi_32 = hi_q;
    assign bus.w_lo_32 = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer: directed corner cases,
//   randomized ops against an arithmetic reference model, interlock
//   and mid-operation reset scenarios.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference: {HI, LO} from plain arithmetic on the ISA rules.
    function automatic logic [63:0] refModel(input logic [5:0] op,
                                             input logic [31:0] rs,
                                             input logic [31:0] rt);
        longint p;
        int     a, b, q, r;
        case (op)
            F_MULTU: return {32'b0, rs} * {32'b0, rt};
            F_MULT: begin
                p = longint'($signed(rs)) * longint'($signed(rt));
                return p;
            end
            F_DIVU: begin
                if (rt == 0) return {rs, 32'hFFFF_FFFF};
                return {rs % rt, rs / rt};
            end
            F_DIV: begin
                if (rt == 0) return {rs, 32'hFFFF_FFFF};
                if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)
                    return {32'h0, 32'h8000_0000};
                a = rs;
                b = rt;
                q = a / b;
                r = a % b;
                return {r, q};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present an issue for one rising edge; returns #1 into cycle 1.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt);
        bus.w_start      = 1'b1;
        bus.w_op_type_6  = op;
        bus.w_rs_data_32 = rs;
        bus.w_rt_data_32 = rt;
        @(posedge clock);
        #1;
        bus.w_start = 1'b0;
    endtask

    // Issue, wait (bounded) for done, check latency, busy span and HI/LO.
    // Leaves the bench sampling inside the DONE cycle.
    task automatic runOp(input string tag, input logic [5:0] op,
                         input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] expv;
        int busyCycles;
        int doneCycle;
        expv = refModel(op, rs, rt);
        applyStimulus(op, rs, rt);
        busyCycles = 0;
        doneCycle  = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (bus.w_done) begin
                doneCycle = cyc;
                break;
            end
            if (bus.w_busy) busyCycles++;
            @(posedge clock);
            #1;
        end
        checkOutput({tag, "_done_cycle"}, 64'(doneCycle), 64'd35);
        checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'd34);
        checkOutput({tag, "_busy_in_done"}, 64'(bus.w_busy), 64'd0);
        checkOutput({tag, "_hilo"}, {bus.w_hi_32, bus.w_lo_32}, expv);
    endtask

    initial begin
        int stallCnt;
        int firstStall;
        int doneCycle;
        int doneSeen;
        logic [5:0] rop;
        logic [31:0] ra, rb;

        bus.w_start      = 1'b0;
        bus.w_op_type_6  = 6'h0;
        bus.w_rs_data_32 = 32'h0;
        bus.w_rt_data_32 = 32'h0;
        bus.w_mf_req     = 1'b0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_busy", 64'(bus.w_busy), 64'd0);
        checkOutput("reset_done", 64'(bus.w_done), 64'd0);
        checkOutput("reset_hi", 64'(bus.w_hi_32), 64'd0);
        checkOutput("reset_lo", 64'(bus.w_lo_32), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed corner cases (back-to-back issues from DONE).
        runOp("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu_max_hi_literal", 64'(bus.w_hi_32), 64'hFFFF_FFFE);
        runOp("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7);
        runOp("mult_min_sq", F_MULT, 32'h8000_0000, 32'h8000_0000);
        runOp("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
        runOp("divu_7_2", F_DIVU, 32'd7, 32'd2);
        runOp("div_by_zero", F_DIV, 32'h1234, 32'h0);
        runOp("divu_by_zero", F_DIVU, 32'hF000_0001, 32'h0);
        runOp("div_overflow", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_overflow_lo_literal", 64'(bus.w_lo_32), 64'h8000_0000);

        // MF request with nothing in flight never stalls.
        @(posedge clock);
        #1;
        bus.w_mf_req = 1'b1;
        #1;
        checkOutput("mf_idle_stall", 64'(bus.w_stall), 64'd0);
        bus.w_mf_req = 1'b0;

        // Interlock: MF held from cycle 5, second issue at cycle 10.
        applyStimulus(F_DIVU, 32'd100, 32'd7);
        stallCnt   = 0;
        firstStall = 0;
        doneCycle  = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            bus.w_mf_req     = (cyc >= 5);
            bus.w_start      = (cyc == 10);
            bus.w_op_type_6  = F_MULTU;
            bus.w_rs_data_32 = 32'd5;
            bus.w_rt_data_32 = 32'd9;
            #1;
            if (cyc == 10) checkOutput("stall_start_and_mf", 64'(bus.w_stall), 64'd1);
            if (bus.w_done) begin
                doneCycle = cyc;
                break;
            end
            if (bus.w_stall) begin
                stallCnt++;
                if (firstStall == 0) firstStall = cyc;
            end
            @(posedge clock);
            #1;
        end
        checkOutput("stall_done_cycle", 64'(doneCycle), 64'd35);
        checkOutput("stall_first_cycle", 64'(firstStall), 64'd5);
        checkOutput("stall_cycle_count", 64'(stallCnt), 64'd30);
        checkOutput("stall_in_done", 64'(bus.w_stall), 64'd0);
        checkOutput("stall_hilo", {bus.w_hi_32, bus.w_lo_32}, refModel(F_DIVU, 32'd100, 32'd7));
        bus.w_mf_req = 1'b0;

        // Reset in cycle 12 of a DIVU aborts with no done pulse.
        @(posedge clock);
        #1;
        applyStimulus(F_DIVU, 32'hDEAD_BEEF, 32'd3);
        doneSeen = 0;
        for (int cyc = 1; cyc < 12; cyc++) begin
            if (bus.w_done) doneSeen++;
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        if (bus.w_done) doneSeen++;
        checkOutput("abort_busy", 64'(bus.w_busy), 64'd0);
        checkOutput("abort_hi", 64'(bus.w_hi_32), 64'd0);
        checkOutput("abort_lo", 64'(bus.w_lo_32), 64'd0);
        checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
        reset = 1'b1;
        runOp("after_reset_multu", F_MULTU, 32'd2, 32'd3);

        // Unknown func code is ignored and HI/LO stay put.
        @(posedge clock);
        #1;
        applyStimulus(6'h20, 32'd11, 32'd13);
        checkOutput("bad_op_busy", 64'(bus.w_busy), 64'd0);
        @(posedge clock);
        #1;
        checkOutput("bad_op_done", 64'(bus.w_done), 64'd0);
        checkOutput("bad_op_hilo", {bus.w_hi_32, bus.w_lo_32}, 64'd6);

        // Randomized ops, mixing back-to-back and gapped issues.
        for (int n = 0; n < 16; n++) begin
            rop = 6'(F_MULT + 6'($urandom_range(0, 3)));
            ra  = pickOperand();
            rb  = pickOperand();
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clock);
                #1;
            end
            runOp($sformatf("rand%0d_op%0h", n, rop), rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Multi-cycle controller for the HI/LO multiply/divide resource behind the decoder's SPECIAL-class ALU ops.
- Accepts MULT, MULTU, DIV and DIVU issues from decode and runs them iteratively: shift-add multiply, restoring divide, one bit per cycle.
- Owns the architectural HI/LO registers.
- Interlocks the pipeline with a stall signal when MFHI/MFLO, or a second issue, arrives while an operation is in flight.

## Interface

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- w_start  in  1  decode issues a mul/div op this cycle.
- w_op_type_6  in  6  SPECIAL func code qualifying w_start: MULT, MULTU, DIV, DIVU.
- w_rs_data_32  in  XLEN  multiplicand / dividend.
- w_rt_data_32  in  XLEN  multiplier / divisor.
- w_mf_req  in  1  decode holds MFHI or MFLO this cycle.
- w_busy  out  1  operation in flight.
- w_stall  out  1  hold decode; combinational, equals w_busy & (w_start | w_mf_req).
- w_done  out  1  one-cycle pulse: new HI/LO visible this cycle.
- w_hi_32  out  XLEN  committed HI register.
- w_lo_32  out  XLEN  committed LO register.

## Operation

States: IDLE, PREP, ITER, FIX, DONE.

Issue and state transitions:
- **IDLE / DONE:** w_start with a valid op_type latches operands, op and signedness, then goes to PREP. w_start with any other op_type is ignored and the state is unchanged.
- **PREP:** for signed ops, takes absolute values and records the result sign (product or quotient: sign_rs XOR sign_rt; remainder: sign_rs). Detects divisor == 0. Loads the iteration counter with XLEN-1. Goes to ITER.
- **ITER:**
  - Multiply: if the multiplier LSB is set, add the multiplicand into the upper accumulator; then shift the 2*XLEN accumulator right by 1.
  - Divide: shift the remainder/quotient pair left by 1; trial-subtract the divisor; if non-negative, keep the difference and set the quotient LSB.
  - Counter decrements each cycle; at 0, go to FIX.
- **FIX:** negates results per the recorded signs and writes HI/LO at the end of the cycle. Goes to DONE.
  - Multiply: HI = upper product, LO = lower product.
  - Divide: LO = quotient, HI = remainder.
- **DONE:** w_done=1, w_busy=0, and new values are on w_hi_32/w_lo_32. Returns to IDLE, or to PREP if a new w_start is accepted.

Arithmetic rules:
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero, signed or unsigned: LO=0xFFFFFFFF, HI=rs, full latency.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0 (two's-complement wrap); no exception.

HI/LO behaviour:
- HI/LO change only on the FIX->DONE edge.
- While busy they hold their previous values, but MFHI/MFLO is stalled anyway.

Interlock:
- w_start while busy is not accepted; w_stall holds decode until DONE.
- w_mf_req with w_busy=0 never stalls.

## Timing

- Issue accepted at edge E0 (cycle 0).
- Cycles 1..XLEN+2 run PREP, ITER and FIX: 1 + XLEN + 1 = 34 cycles with w_busy=1.
- DONE occupies cycle 35 (XLEN=32): w_done=1 and HI/LO valid. MFHI/MFLO in that cycle reads the new value with no stall.
- Back-to-back issue in DONE gives a 35-cycle issue-to-issue period.

Reset values (reset low at an edge):
- State = IDLE, counter = 0, HI = LO = 0, w_busy = 0, w_done = 0.

Reset mid-operation:
- Aborts with no w_done pulse; HI/LO are cleared.
- The first cycle after reset deasserts accepts an issue.

Simultaneous events:
- w_start and w_mf_req together while busy: a single stall covers both.
- w_start and w_mf_req together in DONE: the MF read returns the just-committed value, and the new op starts.

## Structure

- SPECIAL func codes come from the shared ISA codes include; no local redefinition.
- Shared package muldiv_pkg holds the state encoding localparams (IDLE=0, PREP=1, ITER=2, FIX=3, DONE=4) and XLEN-derived counter width.
- One sub-module: muldiv_step, a combinational single-iteration unit (add-shift or subtract-shift selected by an is_div input), instantiated once by the FSM.

## Test plan

- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> w_done in cycle 35; HI=0xFFFFFFFE, LO=0x00000001; w_busy high cycles 1-34.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1.
- DIV rs=0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234 after full latency; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- w_mf_req held from cycle 5 -> w_stall=1 cycles 5-34, 0 in cycle 35 with new HI visible; w_start with a second op at cycle 10 is not accepted and causes no state change.
- reset low at cycle 12 of a DIVU -> cycle 13: w_busy=0, HI=LO=0, no w_done pulse; a fresh MULTU 2x3 then yields LO=6, HI=0.
